// File: rtl/exp_pkg.sv
// Shared widths, FSM state type and saturation limit for the exponential datapath.
package exp_pkg;
  localparam int IN_INT  = 4;
  localparam int FRAC    = 11;
  localparam int OUT_INT = 15;
  localparam int IN_W    = IN_INT + FRAC;
  localparam int OUT_W   = OUT_INT + FRAC;
  localparam int PROD_W  = OUT_W + IN_W;

  localparam logic [OUT_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/fx_mul_sat.sv
// Combinational fixed-point multiply: full-precision product, truncate by FRAC,
// saturate to the output range; saturation propagates from the previous term.
module fx_mul_sat
  import exp_pkg::*;
(
  input  logic [OUT_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  input  logic             sat_in,
  output logic [OUT_W-1:0] y,
  output logic             sat_out
);

  // Returns {sat_flag, value}.
  function automatic logic [OUT_W:0] trunc_sat(input logic [PROD_W-1:0] p,
                                               input logic             s);
    logic [PROD_W-1:0] r;
    r = p >> FRAC;
    if (s || (r > PROD_W'(SAT_MAX)))
      return {1'b1, SAT_MAX};
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic [PROD_W-1:0] prod;
  logic [OUT_W:0]    res;

  assign prod    = PROD_W'(a) * PROD_W'(b);
  assign res     = trunc_sat(prod, sat_in);
  assign y       = res[OUT_W-1:0];
  assign sat_out = res[OUT_W];

endmodule

// File: rtl/power_series_gen.sv
// Generates X^1..X^NUM_TERMS one term per cycle through a single shared
// saturating fixed-point multiplier, with valid/ready on both sides.
module power_series_gen
  import exp_pkg::*;
#(
  parameter int NUM_TERMS = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IN_W-1:0]            X,
  input  logic                       I_valid,
  output logic                       I_ready,
  output logic                       mul_valid,
  input  logic                       mul_ready,
  output logic [NUM_TERMS*OUT_W-1:0] terms,
  output logic [NUM_TERMS-1:0]       sat
);

  localparam int KW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_TERMS - 1);

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        k_prev;
  logic [IN_W-1:0]      x_q;
  logic [OUT_W-1:0]     term_q [NUM_TERMS];
  logic [NUM_TERMS-1:0] sat_q;
  logic                 accept;
  logic [OUT_W-1:0]     mul_y;
  logic                 mul_sat;

  always_comb begin
    state_d   = state_q;
    I_ready   = 1'b0;
    mul_valid = 1'b0;
    case (state_q)
      IDLE: begin
        I_ready = rst_n;
        if (I_valid)
          state_d = (NUM_TERMS == 1) ? DONE : CALC;
      end
      CALC: begin
        if (k_q == K_LAST)
          state_d = DONE;
      end
      DONE: begin
        mul_valid = 1'b1;
        if (mul_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = I_valid && I_ready;
  assign k_prev = k_q - KW'(1);

  fx_mul_sat u_mul (
    .a       (term_q[k_prev]),
    .b       (x_q),
    .sat_in  (sat_q[k_prev]),
    .y       (mul_y),
    .sat_out (mul_sat)
  );

  // State, operand and term array; reset clears everything so an aborted
  // operation leaves no stale terms behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      sat_q   <= '0;
      for (int i = 0; i < NUM_TERMS; i++)
        term_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q       <= X;
        term_q[0] <= OUT_W'(X);
        sat_q     <= '0;
        k_q       <= KW'(1);
      end else if (state_q == CALC) begin
        term_q[k_q] <= mul_y;
        sat_q[k_q]  <= mul_sat;
        k_q         <= k_q + KW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_TERMS; g++) begin : g_pack
    assign terms[g*OUT_W +: OUT_W] = term_q[g];
  end

  assign sat = sat_q;

endmodule

// File: tb/tb_power_series_gen.sv
// Scoreboard bench for power_series_gen: randomized and directed operands checked
// against an arithmetic model of the power series with sticky saturation.
module tb_power_series_gen;
  import exp_pkg::*;

  localparam int NT = 6;
  localparam longint MAXV = (64'd1 << OUT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [IN_W-1:0]     X = '0;
  logic                I_valid = 1'b0;
  logic                I_ready;
  logic                mul_valid;
  logic                mul_ready = 1'b1;
  logic [NT*OUT_W-1:0] terms;
  logic [NT-1:0]       sat;

  logic [IN_W-1:0]     X1 = '0;
  logic                v1 = 1'b0;
  logic                r1_rdy;
  logic                mv1;
  logic [OUT_W-1:0]    terms1;
  logic [0:0]          sat1;

  power_series_gen #(.NUM_TERMS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .I_valid(I_valid), .I_ready(I_ready),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .terms(terms), .sat(sat)
  );

  power_series_gen #(.NUM_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .X(X1), .I_valid(v1), .I_ready(r1_rdy),
    .mul_valid(mv1), .mul_ready(1'b1), .terms(terms1), .sat(sat1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT*OUT_W-1:0] t;
    logic [NT-1:0]       s;
    int                  acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_last = 0;
  bit   rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rand_bp) mul_ready = 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input int x);
    exp_t   e;
    longint t;
    bit     s;
    t = x;
    s = 0;
    e.t = '0;
    e.s = '0;
    e.acc = 0;
    for (int k = 0; k < NT; k++) begin
      if (k > 0) begin
        if (s || (t * x) / (64'd1 << FRAC) > MAXV) begin
          t = MAXV;
          s = 1;
        end else begin
          t = (t * x) / (64'd1 << FRAC);
        end
      end
      e.t[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
      e.s[k] = s;
    end
    return e;
  endfunction

  // Monitor: pop on each new result, then check it stays put while held.
  initial begin : monitor
    exp_t cur;
    bit   seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mul_valid && !seen) begin
        seen = 1;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got terms %0h with empty queue", terms);
        end else begin
          cur = sbq.pop_front();
          chk("terms", 160'(terms), 160'(cur.t));
          chk("sat", 160'(sat), 160'(cur.s));
          chk("latency", 160'(cyc - cur.acc), 160'(NT - 1));
        end
      end else if (mul_valid && seen) begin
        chk("hold_terms", 160'(terms), 160'(cur.t));
        chk("hold_sat", 160'(sat), 160'(cur.s));
      end
      if (mul_valid) chk("no_ready_in_done", 160'(I_ready), 160'(0));
      if (!mul_valid) seen = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [IN_W-1:0] x, input bit expect_out);
    int   n;
    exp_t e;
    n = 0;
    I_valid = 1'b1;
    X = x;
    while (!I_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!I_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: I_ready stayed %0d, expected 1", I_ready);
    end else begin
      acc_last = cyc + 1;
      if (expect_out) begin
        e = model(int'(x));
        e.acc = acc_last;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    I_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || mul_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
  endtask

  initial begin : stim
    int cr;
    int n;
    logic [IN_W-1:0] dir [6];
    dir = '{15'd2048, 15'd4096, 15'd3072, 15'd1, 15'd32767, 15'd0};

    repeat (3) @(negedge clk);
    chk("rst_I_ready", 160'(I_ready), 160'(0));
    chk("rst_mul_valid", 160'(mul_valid), 160'(0));
    chk("rst_terms", 160'(terms), 160'(0));
    chk("rst_sat", 160'(sat), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_I_ready", 160'(I_ready), 160'(1));

    foreach (dir[i]) send(dir[i], 1);
    drain();

    rand_bp = 1;
    for (int i = 0; i < 40; i++) begin
      send(IN_W'($urandom_range(0, 32767)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_bp = 0;
    mul_ready = 1'b1;
    drain();

    // Backpressure while a new operand is offered.
    mul_ready = 1'b0;
    send(15'd1234, 1);
    n = 0;
    while (!mul_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_mul_valid", 160'(mul_valid), 160'(1));
    for (int i = 0; i < 10; i++) begin
      I_valid = 1'b1;
      X = 15'd777;
      chk("bp_I_ready", 160'(I_ready), 160'(0));
      @(negedge clk);
    end
    mul_ready = 1'b1;
    cr = cyc + 1;
    send(15'd777, 1);
    chk("bp_next_accept", 160'(acc_last), 160'(cr + 1));
    drain();

    // Abort mid-operation: reset sampled on E3.
    send(15'd4321, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_terms", 160'(terms), 160'(0));
    chk("abort_sat", 160'(sat), 160'(0));
    chk("abort_mul_valid", 160'(mul_valid), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 160'(I_ready), 160'(1));
    repeat (8) @(negedge clk);
    chk("abort_no_valid", 160'(mul_valid), 160'(0));

    // Single-term instance.
    chk("nt1_ready", 160'(r1_rdy), 160'(1));
    v1 = 1'b1;
    X1 = 15'd5000;
    @(negedge clk);
    v1 = 1'b0;
    chk("nt1_valid", 160'(mv1), 160'(1));
    chk("nt1_term", 160'(terms1), 160'(5000));
    chk("nt1_sat", 160'(sat1), 160'(0));
    @(negedge clk);
    chk("nt1_back_idle", 160'(r1_rdy), 160'(1));
    chk("nt1_valid_low", 160'(mv1), 160'(0));

    send(15'd2048, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
